exp_adjust_pipe: RTL and testbench
==================================

Name: exp_adjust_pipe

Overview:
Parametrised, pipelined exponent unit for the floating-point MAC/DIV datapath of the systolic array processing element. Combines two biased exponents for multiply (e1+e2-BIAS) or divide (e1-e2+BIAS), and applies the mantissa-normalisation increment. Classifies zero, infinity, overflow and underflow, and saturates the result. Successor to the fixed 8-bit BFLOAT16 exponent rounder: it adds width/bias parameters, a divide mode, a valid/ready handshake with backpressure, per-result flags, and sticky status registers.

Parameters:
EXP_W, 8, exponent field width (8 = BFLOAT16/FP32, 5 = FP16).
BIAS, 2**(EXP_W-1)-1, exponent bias.
EMAX, 2**EXP_W-2, largest finite biased exponent; saturation value on overflow.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear of sticky status registers.
in_valid  in  1  operand valid.
in_ready  out  1  unit can accept operands.
mode  in  1  0 = multiply, 1 = divide.
norm_inc  in  1  +1 from mantissa normalisation.
exp_a  in  EXP_W  biased exponent A (dividend for divide).
exp_b  in  EXP_W  biased exponent B (divisor for divide).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
res_exp  out  EXP_W  biased result exponent.
res_zero  out  1  result is zero.
res_inf  out  1  result is infinity (all ones).
res_ovf  out  1  finite overflow, saturated to EMAX.
res_unf  out  1  underflow, clamped to 1.
res_inv  out  1  invalid: 0*inf, 0/0, inf/inf.
ovf_status  out  1  sticky overflow.
unf_status  out  1  sticky underflow.

Behaviour:
- Reset (rst_n low, asynchronous): pipeline valids, all outputs and sticky bits = 0. in_ready = 1 after release. Reset mid-operation discards in-flight data with no partial output.
- Pipeline: 2 stages; latency 2 cycles from an in_valid&in_ready handshake to out_valid when out_ready is held high. Throughput 1 result/cycle.
- Handshake: a stage advances when its successor is empty or being drained. in_ready = !s1_valid | (s1 advances). out_valid is held with stable data until out_ready. No bubbles are inserted under continuous flow.
- Stage 1: compute signed raw value, EXP_W+2 bits wide. Multiply: a+b-BIAS+norm_inc. Divide: a-b+BIAS+norm_inc. Register raw value, special-operand class bits and mode.
- Stage 2, classification in priority order:
  1. invalid → res_exp = all ones, res_inv = 1, res_inf = 1.
  2. zero result (mul: a==0 or b==0; div: a==0, b!=0) → res_exp = 0, res_zero = 1.
  3. infinite result (mul: a or b all ones; div: a all ones, or b==0) → res_exp = all ones, res_inf = 1.
  4. raw > EMAX → res_exp = EMAX, res_ovf = 1.
  5. raw < 1 → res_exp = 1, res_unf = 1.
  6. Otherwise res_exp = raw[EXP_W-1:0].
- Boundaries:
  - raw == EMAX and raw == 1 are legal, with no flag.
  - Exactly one of res_zero / res_inf (alone) / res_ovf / res_unf / none is set per result; res_inv always accompanies res_inf.
- Sticky status:
  - ovf_status / unf_status set on the output handshake (out_valid & out_ready) of a result with res_ovf / res_unf.
  - clr clears them. If clr and a setting handshake coincide, set wins.
  - clr does not affect the pipeline.

Decomposition:
- Shared float package holds:
  - mode encodings MODE_MUL/MODE_DIV.
  - per-format constants: EXP_W, BIAS, EMAX for BF16/FP16.
  - flag-vector field indices.
- One natural sub-module, exp_classify: the stage-2 combinational classify/saturate logic, reused by the future adder-path exponent unit.

Test Plan:
- mul, a=130, b=125, norm_inc=0, out_ready=1 → res_exp=128, no flags, out_valid 2 cycles after handshake.
- mul, a=254,b=127 → 254 no flag. a=254,b=128 → 254, res_ovf=1, ovf_status=1 next cycle; then clr → ovf_status=0.
- mul, a=1,b=126 → raw 0 → res_exp=1, res_unf=1. a=1,b=126,norm_inc=1 → 1, no flag. a=0,b=200 → 0, res_zero=1, no unf.
- div, a=130,b=125 → 132. a=50,b=0 → all ones, res_inf. a=0,b=0 → res_inv=1. a=255,b=255 → res_inv=1.
- Stream 8 operands back-to-back with out_ready held low 3 cycles mid-stream → in_ready drops after 2 accepted, no loss/duplication, results in order. clr concurrent with an ovf handshake → ovf_status=1.
- Assert rst_n low with 2 results in flight → out_valid=0 immediately, sticky bits 0, no stale output after release.

Source files
------------

// File: rtl/exp_adjust_pipe_pkg.sv
// exp_adjust_pipe_pkg: shared float exponent constants, mode encodings and flag-vector layout
package exp_adjust_pipe_pkg;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_BIAS = 127;
  localparam int BF16_EMAX = 254;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_BIAS = 15;
  localparam int FP16_EMAX = 30;
  localparam int FLAG_W = 5;
  localparam int F_ZERO = 0;
  localparam int F_INF = 1;
  localparam int F_OVF = 2;
  localparam int F_UNF = 3;
  localparam int F_INV = 4;
  typedef struct packed {
    logic a_zero;
    logic a_inf;
    logic b_zero;
    logic b_inf;
  } op_class_t;
endpackage

// File: rtl/exp_adjust_pipe_classify.sv
// exp_classify: special-operand classification and saturation of a signed raw exponent
module exp_classify
  import exp_adjust_pipe_pkg::*;
#(
  parameter int EXP_W = BF16_EXP_W,
  parameter int EMAX = 2**EXP_W-2
) (
  input  logic signed [EXP_W+1:0] raw,
  input  logic                    mode,
  input  op_class_t               cls,
  output logic [EXP_W-1:0]        res_exp,
  output logic [FLAG_W-1:0]       flags
);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'(EMAX);
  logic div, inv, zero, inf;
  assign div = mode == MODE_DIV;
  assign inv = div ? (cls.a_zero & cls.b_zero) | (cls.a_inf & cls.b_inf)
                   : (cls.a_zero & cls.b_inf) | (cls.a_inf & cls.b_zero);
  assign zero = div ? cls.a_zero & !cls.b_zero : cls.a_zero | cls.b_zero;
  assign inf = div ? cls.a_inf | cls.b_zero : cls.a_inf | cls.b_inf;
  always_comb begin
    flags = '0;
    res_exp = raw[EXP_W-1:0];
    if (inv) begin
      res_exp = '1;
      flags[F_INV] = 1'b1;
      flags[F_INF] = 1'b1;
    end else if (zero) begin
      res_exp = '0;
      flags[F_ZERO] = 1'b1;
    end else if (inf) begin
      res_exp = '1;
      flags[F_INF] = 1'b1;
    end else if (raw > EMAX_S) begin
      res_exp = EMAX_S[EXP_W-1:0];
      flags[F_OVF] = 1'b1;
    end else if (raw[EXP_W+1] || raw == '0) begin
      res_exp = EXP_W'(1);
      flags[F_UNF] = 1'b1;
    end
  end
endmodule

// File: rtl/exp_adjust_pipe.sv
// exp_adjust_pipe: two-stage mul/div exponent combine with classification, handshake and sticky status
module exp_adjust_pipe
  import exp_adjust_pipe_pkg::*;
#(
  parameter int EXP_W = BF16_EXP_W,
  parameter int BIAS = 2**(EXP_W-1)-1,
  parameter int EMAX = 2**EXP_W-2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             norm_inc,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] res_exp,
  output logic             res_zero,
  output logic             res_inf,
  output logic             res_ovf,
  output logic             res_unf,
  output logic             res_inv,
  output logic             ovf_status,
  output logic             unf_status
);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  logic s1_valid, s1_mode, s1_adv, in_hs, out_hs;
  logic signed [EXP_W+1:0] a_x, b_x, inc_x, raw_d, s1_raw;
  op_class_t cls_d, s1_cls;
  logic [EXP_W-1:0] c_exp;
  logic [FLAG_W-1:0] c_flags, s2_flags;
  assign s1_adv = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | s1_adv;
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign a_x = {2'b00, exp_a};
  assign b_x = {2'b00, exp_b};
  assign inc_x = {{(EXP_W+1){1'b0}}, norm_inc};
  assign raw_d = mode == MODE_DIV ? a_x - b_x + BIAS_S + inc_x : a_x + b_x - BIAS_S + inc_x;
  assign cls_d = '{a_zero: exp_a == '0, a_inf: &exp_a, b_zero: exp_b == '0, b_inf: &exp_b};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode <= 1'b0;
      s1_raw <= '0;
      s1_cls <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_hs) begin
        s1_mode <= mode;
        s1_raw <= raw_d;
        s1_cls <= cls_d;
      end
    end
  end
  exp_classify #(.EXP_W(EXP_W), .EMAX(EMAX)) u_classify (
    .raw(s1_raw),
    .mode(s1_mode),
    .cls(s1_cls),
    .res_exp(c_exp),
    .flags(c_flags)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_exp <= '0;
      s2_flags <= '0;
    end else begin
      if (!out_valid || out_ready) out_valid <= s1_valid;
      if (s1_adv) begin
        res_exp <= c_exp;
        s2_flags <= c_flags;
      end
    end
  end
  assign res_zero = s2_flags[F_ZERO];
  assign res_inf = s2_flags[F_INF];
  assign res_ovf = s2_flags[F_OVF];
  assign res_unf = s2_flags[F_UNF];
  assign res_inv = s2_flags[F_INV];
  // A setting handshake takes precedence over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_status <= 1'b0;
      unf_status <= 1'b0;
    end else begin
      ovf_status <= (out_hs && res_ovf) ? 1'b1 : clr ? 1'b0 : ovf_status;
      unf_status <= (out_hs && res_unf) ? 1'b1 : clr ? 1'b0 : unf_status;
    end
  end
endmodule

// File: tb/tb_exp_adjust_pipe.sv
// tb_exp_adjust_pipe: directed and randomized checks of exp_adjust_pipe against an arithmetic reference model
module tb_exp_adjust_pipe;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, mode = 1'b0, norm_inc = 1'b0, out_ready = 1'b1;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic in_ready, out_valid, res_zero, res_inf, res_ovf, res_unf, res_inv, ovf_status, unf_status;
  logic [7:0] res_exp;
  typedef struct packed {
    logic [7:0] e;
    logic [4:0] f;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, idx = 0;
  bit sov = 0, suf = 0, ih = 0;

  exp_adjust_pipe dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .norm_inc(norm_inc), .exp_a(exp_a), .exp_b(exp_b),
    .out_valid(out_valid), .out_ready(out_ready), .res_exp(res_exp),
    .res_zero(res_zero), .res_inf(res_inf), .res_ovf(res_ovf), .res_unf(res_unf),
    .res_inv(res_inv), .ovf_status(ovf_status), .unf_status(unf_status)
  );

  always #5 clk = ~clk;

  // flags packed as {inv, unf, ovf, inf, zero}
  function automatic exp_t model(bit m, bit inc, int a, int b);
    exp_t r;
    int raw;
    raw = m ? a - b + 127 + int'(inc) : a + b - 127 + int'(inc);
    r = '0;
    if (m ? (a == 0 && b == 0) || (a == 255 && b == 255) : (a == 0 && b == 255) || (a == 255 && b == 0)) begin
      r.e = 8'd255; r.f = 5'b10010;
    end else if (m ? (a == 0 && b != 0) : (a == 0 || b == 0)) begin
      r.e = 8'd0; r.f = 5'b00001;
    end else if (m ? (a == 255 || b == 0) : (a == 255 || b == 255)) begin
      r.e = 8'd255; r.f = 5'b00010;
    end else if (raw > 254) begin
      r.e = 8'd254; r.f = 5'b00100;
    end else if (raw < 1) begin
      r.e = 8'd1; r.f = 5'b01000;
    end else r.e = 8'(raw);
    return r;
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 126;
      3: return 127;
      4: return 128;
      5: return 254;
      6: return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(output bit acc);
    bit oh;
    exp_t e;
    e = '0;
    #1;
    acc = in_valid && in_ready;
    oh = out_valid && out_ready;
    if (oh) begin
      if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("res_exp", 32'(res_exp), 32'(e.e));
        chk("res_flags", 32'({res_inv, res_unf, res_ovf, res_inf, res_zero}), 32'(e.f));
      end
    end
    if (acc) q.push_back(model(mode, norm_inc, int'(exp_a), int'(exp_b)));
    if (oh && e.f[2]) sov = 1; else if (clr) sov = 0;
    if (oh && e.f[3]) suf = 1; else if (clr) suf = 0;
    @(posedge clk);
    #1;
    chk("ovf_status", 32'(ovf_status), 32'(sov));
    chk("unf_status", 32'(unf_status), 32'(suf));
  endtask

  task automatic drive(bit m, bit inc, int a, int b);
    mode = m; norm_inc = inc; exp_a = 8'(a); exp_b = 8'(b); in_valid = 1'b1;
  endtask

  task automatic send(bit m, bit inc, int a, int b);
    bit acc;
    int n;
    drive(m, inc, a, b);
    n = 0;
    do begin tick(acc); n++; end while (!acc && n < 10);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (q.size() > 0 && n < 10) begin tick(acc); n++; end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res_exp", 32'(res_exp), 32'd0);
    chk("rst_flags", 32'({res_inv, res_unf, res_ovf, res_inf, res_zero}), 32'd0);
    chk("rst_sticky", 32'({ovf_status, unf_status}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    drive(0, 0, 130, 125);
    tick(ih);
    chk("lat_accept", 32'(ih), 32'd1);
    in_valid = 1'b0;
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    tick(ih);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    chk("lat_value", 32'(res_exp), 32'd128);
    tick(ih);
    send(0, 0, 254, 127);
    send(0, 0, 254, 128);
    drain();
    chk("ovf_set", 32'(ovf_status), 32'd1);
    clr = 1'b1;
    tick(ih);
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf_status), 32'd0);
    send(0, 0, 1, 126);
    send(0, 1, 1, 126);
    send(0, 0, 0, 200);
    send(1, 0, 130, 125);
    send(1, 0, 50, 0);
    send(1, 0, 0, 0);
    send(1, 0, 255, 255);
    send(0, 0, 0, 255);
    send(1, 0, 0, 255);
    drain();
    chk("unf_set", 32'(unf_status), 32'd1);
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      if (idx < 8) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
      else in_valid = 1'b0;
      out_ready = !(c >= 3 && c <= 5);
      tick(ih);
      if (c == 5) chk("stall_in_ready", 32'(ih), 32'd0);
      if (ih) idx++;
    end
    drain();
    chk("stream_count", 32'(idx), 32'd8);
    clr = 1'b1;
    tick(ih);
    clr = 1'b0;
    drive(0, 0, 254, 200);
    tick(ih);
    in_valid = 1'b0;
    tick(ih);
    clr = 1'b1;
    tick(ih);
    clr = 1'b0;
    chk("clr_vs_set", 32'(ovf_status), 32'd1);
    out_ready = 1'b0;
    send(0, 0, 1, 100);
    send(0, 0, 60, 70);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sticky", 32'({ovf_status, unf_status}), 32'd0);
    q.delete();
    sov = 0; suf = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (3) begin
      tick(ih);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    repeat (300) begin
      if ($urandom_range(0, 1) == 1) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
      else in_valid = 1'b0;
      out_ready = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 19) == 0;
      tick(ih);
    end
    clr = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
